// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI bus sequencer: FSM state encoding,
// HPI register selects and the width of the phase-timing down-counter.
package hpi_pkg;

  localparam int unsigned HPI_CNT_W = 4;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } hpi_state_t;

  // A phase of N cycles loads N-1 so the state exits when the counter reads zero.
  function automatic logic [HPI_CNT_W-1:0] cnt_load(input int unsigned cycles);
    return HPI_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/hpi_int_sync.sv
// Two-flop synchronizer plus rising-edge detector for the asynchronous OTG
// interrupt line; only present in builds that define HPI_INT_SYNC_EN.
`ifdef HPI_INT_SYNC_EN
module hpi_int_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule
`endif

// File: rtl/hpi_bus_sequencer.sv
// Timed HPI bus master: turns one request/response handshake into a complete
// CS/RD/WR access. Optional interrupt synchronizer under HPI_INT_SYNC_EN.
module hpi_bus_sequencer
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in
`ifdef HPI_INT_SYNC_EN
  ,
  input  logic        otg_int,
  output logic        irq_pulse
`endif
);

  localparam int unsigned CNT_MAX = (1 << HPI_CNT_W) - 1;

  if (SETUP_CYC > CNT_MAX || STROBE_CYC == 0 || STROBE_CYC > CNT_MAX ||
      HOLD_CYC > CNT_MAX || RECOVER_CYC > CNT_MAX) begin : g_bad_timing
    $error("hpi_bus_sequencer: cycle count parameter out of range");
  end

  localparam logic [HPI_CNT_W-1:0] LD_SETUP   = cnt_load(SETUP_CYC);
  localparam logic [HPI_CNT_W-1:0] LD_STROBE  = cnt_load(STROBE_CYC);
  localparam logic [HPI_CNT_W-1:0] LD_HOLD    = cnt_load(HOLD_CYC);
  localparam logic [HPI_CNT_W-1:0] LD_RECOVER = cnt_load(RECOVER_CYC);

  hpi_state_t           state;
  hpi_state_t           nxt_state;
  logic [HPI_CNT_W-1:0] cnt;
  logic [HPI_CNT_W-1:0] nxt_cnt;
  logic                 wr_flag;
  logic                 nxt_write;
  logic                 accept;
  logic                 cnt_done;
  logic                 nxt_bus_active;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign cnt_done  = (cnt == '0);
  assign nxt_write = accept ? req_write : wr_flag;

  // Zero-length phases are skipped at elaboration-time-constant branches so
  // every phase that is entered lasts at least one cycle.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt_done ? '0 : cnt - 1'b1;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (SETUP_CYC != 0) begin
            nxt_state = SETUP;
            nxt_cnt   = LD_SETUP;
          end else begin
            nxt_state = STROBE;
            nxt_cnt   = LD_STROBE;
          end
        end
      end
      SETUP: begin
        if (cnt_done) begin
          nxt_state = STROBE;
          nxt_cnt   = LD_STROBE;
        end
      end
      STROBE: begin
        if (cnt_done) begin
          if (HOLD_CYC != 0) begin
            nxt_state = HOLD;
            nxt_cnt   = LD_HOLD;
          end else if (RECOVER_CYC != 0) begin
            nxt_state = RECOVER;
            nxt_cnt   = LD_RECOVER;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      HOLD: begin
        if (cnt_done) begin
          if (RECOVER_CYC != 0) begin
            nxt_state = RECOVER;
            nxt_cnt   = LD_RECOVER;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      RECOVER: begin
        if (cnt_done) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign nxt_bus_active = (nxt_state == SETUP) || (nxt_state == STROBE) ||
                          (nxt_state == HOLD);

  // Pin values are decoded from the upcoming state so they change on the same
  // edge as the state register, keeping every output a plain flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_flag      <= 1'b0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_data_oe  <= 1'b0;
      otg_addr     <= '0;
      otg_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      wr_flag     <= nxt_write;
      otg_cs_n    <= !nxt_bus_active;
      otg_rd_n    <= !((nxt_state == STROBE) && !nxt_write);
      otg_wr_n    <= !((nxt_state == STROBE) && nxt_write);
      otg_data_oe <= nxt_bus_active && nxt_write;
      rsp_valid   <= (state != IDLE) && (nxt_state == IDLE);
      if (accept) begin
        otg_addr     <= req_addr;
        otg_data_out <= req_wdata;
      end
      if ((state == STROBE) && cnt_done && !wr_flag) begin
        rsp_rdata <= otg_data_in;
      end
    end
  end

`ifdef HPI_INT_SYNC_EN
  hpi_int_sync u_int_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (otg_int),
    .pulse    (irq_pulse)
  );
`endif

endmodule
